// File: rtl/boid_update_seq.sv
// Boid state updater: walks every boid once per start, integrates velocity
// and position, reflects at the walls and writes all fields back.
module boid_update_seq #(
    parameter int num_boids = 2,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 620,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 460
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(num_boids):0]  which_boid,
    output logic [6:0]                  wb_en,
    input  logic [31:0]                 x_rd,
    input  logic [31:0]                 y_rd,
    input  logic [31:0]                 vx_rd,
    input  logic [31:0]                 vy_rd,
    input  logic [31:0]                 vx_acc_rd,
    input  logic [31:0]                 vy_acc_rd,
    output logic [31:0]                 x_wr,
    output logic [31:0]                 y_wr,
    output logic [31:0]                 vx_wr,
    output logic [31:0]                 vy_wr,
    output logic [31:0]                 vx_acc_wr,
    output logic [31:0]                 vy_acc_wr
);

    localparam int IW = $clog2(num_boids) + 1;
    localparam logic [IW-1:0] LAST = IW'(num_boids - 1);

    localparam logic signed [32:0] VMAX = 33'sd1048575;
    localparam logic signed [32:0] VMIN = -33'sd1048576;

    localparam logic signed [33:0] XLO = 34'(X_MIN) <<< 16;
    localparam logic signed [33:0] XHI = 34'(X_MAX) <<< 16;
    localparam logic signed [33:0] YLO = 34'(Y_MIN) <<< 16;
    localparam logic signed [33:0] YHI = 34'(Y_MAX) <<< 16;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LATCH,
        CALC,
        WRITE,
        DONE
    } state_t;

    state_t state_q, state_d;
    logic [IW-1:0] idx_q;

    logic [31:0] lx, ly, lvx, lvy, lax, lay;
    logic [63:0] x_res, y_res;

    // v + acc in 33 bits so a 32-bit overflow still clamps the right way
    function automatic logic [31:0] sat_vel(input logic [31:0] v,
                                            input logic [31:0] a);
        logic signed [32:0] s;
        s = $signed({v[31], v}) + $signed({a[31], a});
        if (s > VMAX) return 32'h000F_FFFF;
        if (s < VMIN) return 32'hFFF0_0000;
        return s[31:0];
    endfunction

    // returns {p', v'} for one axis
    function automatic logic [63:0] step_axis(input logic [31:0] p,
                                              input logic [31:0] v,
                                              input logic [31:0] a,
                                              input logic signed [33:0] lo,
                                              input logic signed [33:0] hi);
        logic [31:0] vt;
        logic [31:0] mag;
        logic signed [33:0] pt;
        vt  = sat_vel(v, a);
        mag = vt[31] ? (~vt + 32'd1) : vt;
        pt  = $signed({{2{p[31]}}, p}) + $signed({{2{vt[31]}}, vt});
        if (pt < lo) return {lo[31:0], mag};
        if (pt > hi) return {hi[31:0], ~mag + 32'd1};
        return {pt[31:0], vt};
    endfunction

    assign x_res = step_axis(lx, lvx, lax, XLO, XHI);
    assign y_res = step_axis(ly, lvy, lay, YLO, YHI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lx      <= '0;
            ly      <= '0;
            lvx     <= '0;
            lvy     <= '0;
            lax     <= '0;
            lay     <= '0;
            x_wr    <= '0;
            y_wr    <= '0;
            vx_wr   <= '0;
            vy_wr   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start) idx_q <= '0;
                LATCH: begin
                    lx  <= x_rd;
                    ly  <= y_rd;
                    lvx <= vx_rd;
                    lvy <= vy_rd;
                    lax <= vx_acc_rd;
                    lay <= vy_acc_rd;
                end
                CALC: begin
                    x_wr  <= x_res[63:32];
                    vx_wr <= x_res[31:0];
                    y_wr  <= y_res[63:32];
                    vy_wr <= y_res[31:0];
                end
                WRITE: if (idx_q != LAST) idx_q <= idx_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = ADDR;
            ADDR:  state_d = LATCH;
            LATCH: state_d = CALC;
            CALC:  state_d = WRITE;
            WRITE: state_d = (idx_q == LAST) ? DONE : ADDR;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign wb_en      = (state_q == WRITE) ? 7'h7F : 7'h00;
    assign which_boid = idx_q;
    assign vx_acc_wr  = '0;
    assign vy_acc_wr  = '0;

endmodule

// File: tb/tb_boid_update_seq.sv
// Bench for boid_update_seq: two-boid memory model, write scoreboard and
// per-cycle handshake checks.
module tb_boid_update_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [1:0]  which_boid;
    logic [6:0]  wb_en;
    logic [31:0] x_rd, y_rd, vx_rd, vy_rd, vx_acc_rd, vy_acc_rd;
    logic [31:0] x_wr, y_wr, vx_wr, vy_wr, vx_acc_wr, vy_acc_wr;

    logic [31:0] mem [0:1][0:5];
    logic [31:0] wrv [0:5];
    logic        ld = 1'b0;
    int          ld_i = 0;
    logic [31:0] ld_v [0:5];

    typedef struct {
        logic [1:0]  i;
        logic [31:0] x, y, vx, vy;
    } wr_t;
    wr_t q[$];

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    boid_update_seq dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done),
        .which_boid(which_boid), .wb_en(wb_en),
        .x_rd(x_rd), .y_rd(y_rd), .vx_rd(vx_rd), .vy_rd(vy_rd),
        .vx_acc_rd(vx_acc_rd), .vy_acc_rd(vy_acc_rd),
        .x_wr(x_wr), .y_wr(y_wr), .vx_wr(vx_wr), .vy_wr(vy_wr),
        .vx_acc_wr(vx_acc_wr), .vy_acc_wr(vy_acc_wr)
    );

    always #5 clk = ~clk;

    assign x_rd      = mem[which_boid[0]][0];
    assign y_rd      = mem[which_boid[0]][1];
    assign vx_rd     = mem[which_boid[0]][2];
    assign vy_rd     = mem[which_boid[0]][3];
    assign vx_acc_rd = mem[which_boid[0]][4];
    assign vy_acc_rd = mem[which_boid[0]][5];

    always_comb begin
        wrv[0] = x_wr;
        wrv[1] = y_wr;
        wrv[2] = vx_wr;
        wrv[3] = vy_wr;
        wrv[4] = vx_acc_wr;
        wrv[5] = vy_acc_wr;
    end

    always @(posedge clk) begin
        if (ld) begin
            for (int f = 0; f < 6; f++) mem[ld_i][f] <= ld_v[f];
        end else if (wb_en[0]) begin
            for (int f = 0; f < 6; f++)
                if (wb_en[f+1]) mem[which_boid[0]][f] <= wrv[f];
        end
    end

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every write strobe must match the next expected record
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (wb_en != 7'h00) begin
            if (q.size() == 0) begin
                check("unexpected_write", 256'(wb_en), 256'(0));
            end else begin
                wr_t e;
                e = q.pop_front();
                check("write",
                      {wb_en, which_boid, x_wr, y_wr, vx_wr, vy_wr,
                       vx_acc_wr, vy_acc_wr},
                      {7'h7F, e.i, e.x, e.y, e.vx, e.vy, 64'd0});
            end
        end
    end

    task automatic load(input int i, input logic [31:0] x, y, vx, vy, ax, ay);
        @(negedge clk);
        ld_i    = i;
        ld_v[0] = x;
        ld_v[1] = y;
        ld_v[2] = vx;
        ld_v[3] = vy;
        ld_v[4] = ax;
        ld_v[5] = ay;
        ld      = 1'b1;
        @(negedge clk);
        ld      = 1'b0;
    endtask

    task automatic expect_w(input logic [1:0] i, input logic [31:0] x, y, vx, vy);
        wr_t e;
        e.i  = i;
        e.x  = x;
        e.y  = y;
        e.vx = vx;
        e.vy = vy;
        q.push_back(e);
    endtask

    // start at edge 0, then check {busy,done,wb_en,which_boid} in cycles 1..12
    task automatic run_pass(input bit repulse);
        logic [10:0] exp;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clk);
            if (repulse) start = (c == 3);
            exp = {c <= 9, c == 9,
                   (c == 4 || c == 8) ? 7'h7F : 7'h00,
                   (c <= 4) ? 2'd0 : 2'd1};
            check($sformatf("handshake_c%0d", c),
                  256'({busy, done, wb_en, which_boid}), 256'(exp));
        end
        start = 1'b0;
    endtask

    initial begin
        int d0;
        for (int f = 0; f < 6; f++) begin
            ld_v[f]   = '0;
            mem[0][f] = '0;
            mem[1][f] = '0;
        end
        #1;
        check("reset_ctrl", 256'({busy, done, wb_en, which_boid}), 256'(0));
        check("reset_data",
              {x_wr, y_wr, vx_wr, vy_wr, vx_acc_wr, vy_acc_wr}, 256'(0));
        #3 reset = 1'b1;

        // straight move + right-wall bounce, with a stray start mid-pass
        load(0, 32'h0078_0000, 32'h0078_0000, 32'h0005_0000, 32'h0004_0000, 0, 0);
        load(1, 32'h026A_0000, 32'h0064_0000, 32'h0005_0000, 0, 0, 0);
        expect_w(0, 32'h007D_0000, 32'h007C_0000, 32'h0005_0000, 32'h0004_0000);
        expect_w(1, 32'h026C_0000, 32'h0064_0000, 32'hFFFB_0000, 32'h0000_0000);
        d0 = done_cnt;
        run_pass(1);
        check("one_done", 256'(done_cnt - d0), 256'(1));
        check("mem_b0_x", 256'(mem[0][0]), 256'(32'h007D_0000));

        // left-wall bounce + accumulator application
        load(0, 32'h0002_0000, 32'h00C8_0000, 32'hFFFB_0000, 32'hFFFE_0000, 0, 0);
        load(1, 32'h0064_0000, 32'h0050_0000, 32'h0005_0000, 32'h0001_0000,
             32'h0001_0000, 32'h0002_0000);
        expect_w(0, 32'h0000_0000, 32'h00C6_0000, 32'h0005_0000, 32'hFFFE_0000);
        expect_w(1, 32'h006A_0000, 32'h0053_0000, 32'h0006_0000, 32'h0003_0000);
        run_pass(0);
        check("acc_x_clear", 256'(mem[1][4]), 256'(0));
        check("acc_y_clear", 256'(mem[1][5]), 256'(0));

        // saturation both signs + double reflection
        load(0, 32'h0010_0000, 32'h0100_0000, 32'h000F_0000, 32'hFFF1_0000,
             32'h0001_0000, 32'hFFFE_0000);
        load(1, 32'h026B_0000, 32'h0001_0000, 32'h0003_0000, 32'hFFFC_0000, 0, 0);
        expect_w(0, 32'h001F_FFFF, 32'h00F0_0000, 32'h000F_FFFF, 32'hFFF0_0000);
        expect_w(1, 32'h026C_0000, 32'h0000_0000, 32'hFFFD_0000, 32'h0004_0000);
        run_pass(0);

        // exactly at walls, bottom bounce, 32-bit overflow clamp
        load(0, 32'h0267_0000, 32'h01C8_0000, 32'h0005_0000, 32'h0004_0000, 0, 0);
        load(1, 32'h0032_0000, 32'h01CA_0000, 32'h7FFF_0000, 32'h0005_0000,
             32'h7FFF_0000, 0);
        expect_w(0, 32'h026C_0000, 32'h01CC_0000, 32'h0005_0000, 32'h0004_0000);
        expect_w(1, 32'h0041_FFFF, 32'h01CC_0000, 32'h000F_FFFF, 32'hFFFB_0000);
        run_pass(0);

        // reset asserted during the first WRITE: no write, no done
        load(0, 32'h0078_0000, 32'h0078_0000, 32'h0005_0000, 32'h0004_0000, 0, 0);
        load(1, 32'h026A_0000, 32'h0064_0000, 32'h0005_0000, 0, 0, 0);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_ctrl", 256'({busy, done, wb_en, which_boid}), 256'(0));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_no_done", 256'(done_cnt - d0), 256'(0));
        check("rst_idle", 256'(busy), 256'(0));
        check("rst_b0_kept", {mem[0][0], mem[0][1], mem[0][2], mem[0][3]},
              {32'h0078_0000, 32'h0078_0000, 32'h0005_0000, 32'h0004_0000});

        // fresh pass after reset completes normally
        expect_w(0, 32'h007D_0000, 32'h007C_0000, 32'h0005_0000, 32'h0004_0000);
        expect_w(1, 32'h026C_0000, 32'h0064_0000, 32'hFFFB_0000, 32'h0000_0000);
        d0 = done_cnt;
        run_pass(0);
        check("post_rst_done", 256'(done_cnt - d0), 256'(1));
        check("queue_drained", 256'(q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
